// File: rtl/booth_pkg.sv
// Shared types and parameter helpers for the Booth multiplier dispatch front end.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_CLR  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } booth_state_e;

  localparam int BOOTH_WIDTH_DEFAULT  = 32;
  localparam int BOOTH_PROD_W_DEFAULT = 2 * BOOTH_WIDTH_DEFAULT;

  function automatic int booth_prod_width(input int width);
    return 2 * width;
  endfunction

  // Margin over the core's 3*WIDTH+3 worst case before a job is declared hung.
  function automatic int booth_timeout_default(input int width);
    return 4 * width + 8;
  endfunction

endpackage

// File: rtl/booth_dispatch_if.sv
// Operand stream, core start/done handshake and result stream of booth_dispatch.
interface booth_dispatch_if
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH_DEFAULT
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_multiplier;
  logic [WIDTH-1:0]     in_multiplicand;
  logic                 mul_start;
  logic [WIDTH-1:0]     mul_multiplier;
  logic [WIDTH-1:0]     mul_multiplicand;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 out_error;
  logic                 busy;

  modport slave (
    input  in_valid, in_multiplier, in_multiplicand, mul_done, mul_product, out_ready,
    output in_ready, mul_start, mul_multiplier, mul_multiplicand,
    output out_valid, out_product, out_error, busy
  );

  modport master (
    output in_valid, in_multiplier, in_multiplicand, mul_done, mul_product, out_ready,
    input  in_ready, mul_start, mul_multiplier, mul_multiplicand,
    input  out_valid, out_product, out_error, busy
  );
endinterface

// File: rtl/booth_op_fifo.sv
// Small synchronous FIFO holding operand pairs; full flag is registered.
module booth_op_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/booth_dispatch.sv
// Queues operand pairs, runs the Booth core one job at a time and returns products.
module booth_dispatch
  import booth_pkg::*;
#(
  parameter int WIDTH   = BOOTH_WIDTH_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = booth_timeout_default(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  booth_dispatch_if.slave bus
);
  localparam int PW = booth_prod_width(WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

  booth_state_e     state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             mul_start_q, mul_start_d;
  logic [WIDTH-1:0] mplier_q, mcand_q;
  logic             out_valid_q, out_error_q;
  logic [PW-1:0]    out_product_q;

  logic [PW-1:0]    fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             out_free, timed_out, latch, capture, expire, pop;

  booth_op_fifo #(
    .DEPTH (DEPTH),
    .DW    (PW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .pop_i   (pop),
    .wdata_i ({bus.in_multiplier, bus.in_multiplicand}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_free  = !out_valid_q || bus.out_ready;
  assign timed_out = (timer_q == TIMEOUT_T);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        if (timed_out && out_free) state_d = ST_IDLE;
        else if (!bus.mul_done)    state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if ((bus.mul_done || timed_out) && out_free) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // A real done wins over a timeout that expires in the same cycle.
  always_comb begin
    latch       = 1'b0;
    capture     = 1'b0;
    expire      = 1'b0;
    mul_start_d = 1'b0;
    timer_d     = timer_q;
    case (state_q)
      ST_IDLE:  latch = !fifo_empty;
      ST_ISSUE: begin
        mul_start_d = 1'b1;
        timer_d     = '0;
      end
      ST_WAIT_CLR: begin
        mul_start_d = bus.mul_done && !timed_out;
        expire      = timed_out && out_free;
        timer_d     = timed_out ? timer_q : timer_q + 1'b1;
      end
      ST_WAIT_DONE: begin
        capture = bus.mul_done && out_free;
        expire  = !bus.mul_done && timed_out && out_free;
        timer_d = timed_out ? timer_q : timer_q + 1'b1;
      end
      default: ;
    endcase
    pop = capture || expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q       <= '0;
      mul_start_q   <= 1'b0;
      mplier_q      <= '0;
      mcand_q       <= '0;
      out_valid_q   <= 1'b0;
      out_error_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      timer_q     <= timer_d;
      mul_start_q <= mul_start_d;
      if (latch) {mplier_q, mcand_q} <= fifo_rdata;
      if (pop) begin
        out_valid_q   <= 1'b1;
        out_error_q   <= expire;
        out_product_q <= capture ? bus.mul_product : '0;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready         = !fifo_full;
  assign bus.mul_start        = mul_start_q;
  assign bus.mul_multiplier   = mplier_q;
  assign bus.mul_multiplicand = mcand_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_product      = out_product_q;
  assign bus.out_error        = out_error_q;
  assign bus.busy             = (state_q != ST_IDLE) || (fifo_count != '0);
endmodule

// File: doc/booth_dispatch.md
# booth_dispatch

Operand-queue and handshake front end for the team's sequential Booth multiplier core. Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. Drives the core's `start`/`done` protocol one job at a time and returns each signed 2·WIDTH-bit product over a valid/ready result stream. A watchdog guards against a hung core.

## Interface
- `WIDTH`, 32: operand width; product is 2·WIDTH.
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT`, 4·WIDTH+8: max cycles from issue to `mul_done`; core worst case is 3·WIDTH+3.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO not full.
- `in_multiplier` in WIDTH: signed multiplier.
- `in_multiplicand` in WIDTH: signed multiplicand.
- `mul_start` out 1: to core `start`.
- `mul_multiplier` out WIDTH: to core, stable for the whole job.
- `mul_multiplicand` out WIDTH: to core, stable for the whole job.
- `mul_done` in 1: from core `done`, level.
- `mul_product` in 2·WIDTH: from core `product`.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts.
- `out_product` out 2·WIDTH: signed product, or 0 on error.
- `out_error` out 1: result produced by timeout.
- `busy` out 1: FSM not IDLE, or FIFO non-empty.

## Operation
- FIFO push when `in_valid && in_ready`; pop on job completion (capture or timeout).
- FSM states IDLE, ISSUE, WAIT_CLR, WAIT_DONE.
  - IDLE → ISSUE when FIFO non-empty. Latches the FIFO head into the `mul_*` operand registers.
  - ISSUE: `mul_start`=1, timer cleared; → WAIT_CLR.
  - WAIT_CLR: `mul_start` stays 1 until `mul_done`=0 is sampled. This guards against a stale `done` left high by the previous job. Then `mul_start`=0; → WAIT_DONE.
  - WAIT_DONE: on `mul_done`=1, capture `mul_product`, pop, → IDLE. Capture happens only if the output register is empty or drains in the same cycle (`out_valid && out_ready`). Otherwise stay in WAIT_DONE; the core holds its product stable.
- Timer counts every cycle in WAIT_CLR and WAIT_DONE. When it reaches TIMEOUT:
  - load the output register with product 0 and `out_error`=1, pop, → IDLE;
  - `mul_start` is forced to 0.
  - Timeout obeys the same output-register-free rule; the timer saturates while blocked.
- Output register, one entry: `out_valid` set on load, cleared on `out_valid && out_ready` with no simultaneous load. Data is stable while `out_valid && !out_ready`.
- No arithmetic on the product; the pass-through is bit-exact. The timer is `$clog2(TIMEOUT+1)` bits.

## Timing
- Reset values:
  - `in_ready`=1; `out_valid`, `out_error`, `mul_start`, `busy` = 0;
  - `out_product`, `mul_multiplier`, `mul_multiplicand` = 0;
  - FIFO empty, FSM IDLE, timer 0.
- `rst` mid-job abandons the job and flushes the FIFO. `mul_start` is low from the first post-reset cycle.
- Input accepted at edge t: FSM leaves IDLE at t+1, and `mul_start` is high from t+2.
- Result: `out_valid` rises one cycle after `mul_done`=1 is sampled in WAIT_DONE with the output free.
- Push with pop in the same cycle: legal for any count; count is unchanged. When full, `in_ready`=0, so no push occurs.
- `in_ready` is registered from the FIFO count and does not depend combinationally on `out_ready`.
- Back-to-back jobs: the next ISSUE follows IDLE one cycle after capture. There are no idle cycles beyond that.

## Structure
- `booth_pkg`: FSM state enum, `booth_timeout_default(WIDTH)` function, product-width localparam.
- Sub-module `booth_op_fifo`: parameterised sync FIFO (DEPTH, data 2·WIDTH) with full/empty/count. The FSM and output register live in `booth_dispatch`.

## Test plan
- WIDTH=8, real core attached. Push (3, 0xFB), `out_ready`=1 → one result, `out_product`=0xFFF1, `out_error`=0, latency ≤ 3·8+8 cycles.
- Push 4 pairs back-to-back: (0x7F,0x7F), (0x80,0x80), (0x80,0x7F), (0,0x55) → products 0x3F01, 0x4000, 0xC080, 0x0000 in order. `in_ready` drops after the 4th push while the first job runs.
- Hold `out_ready`=0 for 50 cycles with 2 jobs queued → `out_valid` stays 1 and the first product is stable. The FSM parks in WAIT_DONE. Releasing `out_ready` delivers both in order.
- Stub core that never raises `mul_done` → at TIMEOUT, `out_valid`=1, `out_error`=1, `out_product`=0. The next queued job is then issued.
- Stub core with `mul_done` stuck high for 5 cycles after `start` → `mul_start` held through WAIT_CLR. No capture occurs until `done` has gone low and then high.
- Assert `rst` for 1 cycle mid-WAIT_DONE with 3 queued → next cycle shows all reset values, and `in_ready`=1.
